// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC independent WIDTH-bit accumulators with ALU ops, bit-serial shifts and flags.
// Build option: define ACC_BANK_SAT_EN to make ADD/SUB saturate on signed overflow.
module acc_bank #(
    parameter int WIDTH   = 16,
    parameter int NUM_ACC = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] acc,
    output logic [SEL_W-1:0] acc_idx,
    output logic             out_valid,
    output logic             err,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_CLR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_READ = 4'd10;

    localparam logic [SEL_W:0]   NUM_ACC_L = (SEL_W+1)'(NUM_ACC);
    localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_L, SH_R, SH_A} shk_t;

    state_t                         state_q, state_d;
    shk_t                           shk_q, shk_d;
    logic [NUM_ACC-1:0][WIDTH-1:0]  bank_q, bank_d;
    logic [WIDTH-1:0]               work_q, work_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [SEL_W-1:0]               ssel_q, ssel_d;
    logic [WIDTH-1:0]               acc_q, acc_d;
    logic [SEL_W-1:0]               idx_q, idx_d;
    logic                           z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic                           ov_q, ov_d, err_q, err_d;

    logic [WIDTH-1:0] cur, res, step_val;
    logic [WIDTH:0]   sum_ext, dif_ext;
    logic [CNT_W-1:0] amt;
    logic [SEL_W-1:0] done_sel;
    logic             res_c, res_v, step_out, wr_en, done, legal;

    always_comb begin
        state_d  = state_q;
        shk_d    = shk_q;
        bank_d   = bank_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        ssel_d   = ssel_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        ov_d     = 1'b0;
        err_d    = 1'b0;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        wr_en    = 1'b0;
        done     = 1'b0;
        done_sel = sel;

        cur     = bank_q[sel];
        sum_ext = {1'b0, cur} + {1'b0, in};
        dif_ext = {1'b0, cur} - {1'b0, in};
        amt     = (in[CNT_W-1:0] > WIDTH_C) ? WIDTH_C : in[CNT_W-1:0];
        legal   = (op <= OP_READ) && ({1'b0, sel} < NUM_ACC_L);

        // one bit per SHIFT cycle; step_out is the bit leaving the word
        case (shk_q)
            SH_L: begin
                step_val = {work_q[WIDTH-2:0], 1'b0};
                step_out = work_q[WIDTH-1];
            end
            SH_R: begin
                step_val = {1'b0, work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            default: begin
                step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
        endcase

        if (state_q == SHIFT) begin
            work_d = step_val;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                res      = step_val;
                res_c    = step_out;
                wr_en    = 1'b1;
                done     = 1'b1;
                done_sel = ssel_q;
                state_d  = IDLE;
            end
        end else if (in_valid) begin
            if (!legal) begin
                ov_d  = 1'b1;
                err_d = 1'b1;
            end else begin
                done  = 1'b1;
                wr_en = 1'b1;
                case (op)
                    OP_LOAD: res = in;
                    OP_ADD: begin
                        res   = sum_ext[WIDTH-1:0];
                        res_c = sum_ext[WIDTH];
                        res_v = (cur[WIDTH-1] == in[WIDTH-1]) && (res[WIDTH-1] != cur[WIDTH-1]);
                    end
                    OP_SUB: begin
                        res   = dif_ext[WIDTH-1:0];
                        res_c = dif_ext[WIDTH];
                        res_v = (cur[WIDTH-1] != in[WIDTH-1]) && (res[WIDTH-1] != cur[WIDTH-1]);
                    end
                    OP_AND:  res = cur & in;
                    OP_OR:   res = cur | in;
                    OP_XOR:  res = cur ^ in;
                    OP_CLR:  res = '0;
                    OP_SHL, OP_SHR, OP_ASR: begin
                        // zero amount completes immediately with the value unchanged
                        res = cur;
                        if (amt != '0) begin
                            done    = 1'b0;
                            wr_en   = 1'b0;
                            work_d  = cur;
                            cnt_d   = amt;
                            ssel_d  = sel;
                            shk_d   = (op == OP_SHL) ? SH_L : (op == OP_SHR) ? SH_R : SH_A;
                            state_d = SHIFT;
                        end
                    end
                    OP_READ: begin
                        res   = cur;
                        wr_en = 1'b0;
                    end
                    default: res = cur;
                endcase
`ifdef ACC_BANK_SAT_EN
                // overflow direction follows the sign of the current accumulator
                if (((op == OP_ADD) || (op == OP_SUB)) && res_v)
                    res = cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
        end

        if (wr_en)
            bank_d[done_sel] = res;
        if (done) begin
            acc_d = res;
            idx_d = done_sel;
            z_d   = (res == '0);
            n_d   = res[WIDTH-1];
            c_d   = res_c;
            v_d   = res_v;
            ov_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shk_q   <= SH_L;
            bank_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            ssel_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shk_q   <= shk_d;
            bank_q  <= bank_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            ssel_q  <= ssel_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign acc       = acc_q;
    assign acc_idx   = idx_q;
    assign out_valid = ov_q;
    assign err       = err_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;

endmodule
